// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with staged, frame-synchronous
// (tear-free) display update and optional leading-zero suppression.
module seg_scan_driver #(
    parameter int NDIGIT = 4,
    parameter int DIV    = 1024,
    parameter int BLANK  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*NDIGIT-1:0]   data,
    input  logic [NDIGIT-1:0]     dp,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [7:0]            seg_out,
    output logic [NDIGIT-1:0]     dig_sel,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CW = $clog2(DIV);
    localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*NDIGIT-1:0]   stage_data;
    logic [NDIGIT-1:0]     stage_dp;
    logic [4*NDIGIT-1:0]   disp_data;
    logic [NDIGIT-1:0]     disp_dp;

    logic cnt_last;
    logic idx_last;
    logic wrap;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b0001101;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign cnt_last = (cnt == CW'(DIV - 1));
    assign idx_last = (idx == IW'(NDIGIT - 1));
    assign wrap     = cnt_last && idx_last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= '0;
            stage_data <= '0;
            stage_dp   <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_last ? '0 : cnt + 1'b1;
            frame_done <= wrap;
            if (cnt_last)
                idx <= idx_last ? '0 : idx + 1'b1;
            if (load) begin
                stage_data <= data;
                stage_dp   <= dp;
            end
            // Commit takes the pre-edge staging value, so a coincident load
            // lands in staging and stays pending for the next frame.
            if (wrap && pending) begin
                disp_data <= stage_data;
                disp_dp   <= stage_dp;
            end
            pending <= load | (pending & ~wrap);
        end
    end

    logic       blank;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_sup;
    logic       zero_above;
    logic       nib_zero;

    assign blank = (cnt < CW'(BLANK));

    // zero_above tracks "every digit above k is zero" while walking down from the MSD.
    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_sup    = 1'b0;
        zero_above = 1'b1;
        nib_zero   = 1'b0;
        for (int k = NDIGIT - 1; k >= 0; k--) begin
            nib_zero = (disp_data[4*k +: 4] == 4'h0);
            if (idx == IW'(k)) begin
                cur_nib = disp_data[4*k +: 4];
                cur_dp  = disp_dp[k];
                cur_sup = lz_en && (k != 0) && zero_above && nib_zero;
            end
            zero_above = zero_above && nib_zero;
        end
    end

    always_comb begin
        seg_out = 8'h00;
        dig_sel = '0;
        if (!blank) begin
            seg_out = {(cur_sup ? 7'b0000000 : seg_decode(cur_nib)), cur_dp};
            dig_sel = NDIGIT'(1) << idx;
        end
    end

endmodule
